// File: rtl/reduce_gate_pipe.sv
// Registered WIDTH-bit reduction gate (OR/AND/XOR/NOR/NAND/XNOR plus multi-beat
// OR/AND accumulate) with valid/ready handshakes on both sides.
module reduce_gate_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_op,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic [7:0]       out_count
);

    localparam logic S_IDLE  = 1'b0;
    localparam logic S_ACCUM = 1'b1;

    localparam logic [2:0] OP_ACC_OR = 3'd6;

    logic       state_q, state_d;
    logic       acc_q, acc_d;
    logic [7:0] cnt_q, cnt_d;
    logic       op_and_q, op_and_d;
    logic       out_valid_q, out_valid_d;
    logic       out_bit_q, out_bit_d;
    logic [7:0] out_count_q, out_count_d;

    logic       accept;
    logic       beat_bit;
    logic       acc_next;
    logic [7:0] cnt_next;

    function automatic logic reduce_op(input logic [2:0] op, input logic [WIDTH-1:0] d);
        case (op)
            3'd0:    reduce_op = |d;
            3'd1:    reduce_op = &d;
            3'd2:    reduce_op = ^d;
            3'd3:    reduce_op = ~|d;
            3'd4:    reduce_op = ~&d;
            3'd5:    reduce_op = ~^d;
            3'd6:    reduce_op = |d;
            default: reduce_op = &d;
        endcase
    endfunction

    function automatic logic [7:0] sat255_inc(input logic [7:0] c);
        sat255_inc = (c == 8'd255) ? 8'd255 : c + 8'd1;
    endfunction

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // In ACCUM the latched op decides OR vs AND; in_op is not looked at.
    assign beat_bit = op_and_q ? (&in_data) : (|in_data);
    assign acc_next = op_and_q ? (acc_q & beat_bit) : (acc_q | beat_bit);
    assign cnt_next = sat255_inc(cnt_q);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        op_and_d    = op_and_q;
        out_bit_d   = out_bit_q;
        out_count_d = out_count_q;
        out_valid_d = out_valid_q && !out_ready;
        if (accept) begin
            if (state_q == S_IDLE) begin
                if (in_op < OP_ACC_OR || in_last) begin
                    out_bit_d   = reduce_op(in_op, in_data);
                    out_count_d = 8'd1;
                    out_valid_d = 1'b1;
                end else begin
                    acc_d    = reduce_op(in_op, in_data);
                    cnt_d    = 8'd1;
                    op_and_d = in_op[0];
                    state_d  = S_ACCUM;
                end
            end else if (in_last) begin
                out_bit_d   = acc_next;
                out_count_d = cnt_next;
                out_valid_d = 1'b1;
                acc_d       = 1'b0;
                cnt_d       = 8'd0;
                state_d     = S_IDLE;
            end else begin
                acc_d = acc_next;
                cnt_d = cnt_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= 1'b0;
            cnt_q       <= 8'd0;
            op_and_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            op_and_q    <= op_and_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_count_q <= out_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_reduce_gate_pipe.sv
// Bench for reduce_gate_pipe: directed literal cases plus randomized traffic
// checked every cycle against a frame-level reference model.
module tb_reduce_gate_pipe;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [2:0]   in_op;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic         out_bit;
    logic [7:0]   out_count;

    int checks = 0;
    int errors = 0;

    // Reference model state: a pending frame is kept as the list of its beats.
    logic         m_valid;
    logic         m_bit;
    int           m_cnt;
    logic         m_busy;
    logic         m_and;
    logic [W-1:0] m_frame[$];

    reduce_gate_pipe #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_op    (in_op),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_bit  (out_bit),
        .out_count(out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_red(input int op, input logic [W-1:0] d);
        int n;
        n = $countones(d);
        case (op)
            0, 6:    return n > 0;
            1, 7:    return n == W;
            2:       return (n % 2) == 1;
            3:       return n == 0;
            4:       return n != W;
            default: return (n % 2) == 0;
        endcase
    endfunction

    function automatic logic frame_red();
        logic r;
        r = m_and;
        foreach (m_frame[i]) begin
            if (m_and && $countones(m_frame[i]) != W) r = 1'b0;
            if (!m_and && $countones(m_frame[i]) > 0) r = 1'b1;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_bit   = 1'b0;
        m_cnt   = 0;
        m_busy  = 1'b0;
        m_and   = 1'b0;
        m_frame.delete();
    endtask

    task automatic model_step();
        logic rdy, load, rb;
        int   c;
        rdy  = !m_valid || out_ready;
        load = 1'b0;
        rb   = 1'b0;
        c    = 0;
        if (in_valid && rdy) begin
            if (!m_busy) begin
                if (in_op < 6 || in_last) begin
                    rb   = model_red(int'(in_op), in_data);
                    c    = 1;
                    load = 1'b1;
                end else begin
                    m_frame.delete();
                    m_frame.push_back(in_data);
                    m_and  = (in_op == 3'd7);
                    m_busy = 1'b1;
                end
            end else begin
                m_frame.push_back(in_data);
                if (in_last) begin
                    rb     = frame_red();
                    c      = (m_frame.size() > 255) ? 255 : m_frame.size();
                    load   = 1'b1;
                    m_busy = 1'b0;
                    m_frame.delete();
                end
            end
        end
        if (load) begin
            m_valid = 1'b1;
            m_bit   = rb;
            m_cnt   = c;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_out_valid", out_valid, m_valid);
            chk("model_in_ready", in_ready, !m_valid || out_ready);
            if (m_valid) begin
                chk("model_out_bit", out_bit, m_bit);
                chk("model_out_count", out_count, m_cnt);
            end
        end
    end

    task automatic cycle(input logic v, input logic [W-1:0] d, input logic [2:0] op,
                         input logic last, input logic ordy);
        in_valid  = v;
        in_data   = d;
        in_op     = op;
        in_last   = last;
        out_ready = ordy;
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_bit", out_bit, 1'b0);
        chk("rst_out_count", out_count, 8'd0);
        chk("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    function automatic logic [W-1:0] rand_data();
        logic [W-1:0] ones;
        ones = '1;
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return ones;
            2:       return W'($urandom);
            default: return $urandom_range(0, 1) ? (ones ^ (W'(1) << $urandom_range(0, W - 1)))
                                                 : (W'(1) << $urandom_range(0, W - 1));
        endcase
    endfunction

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] d;
        logic         exp;
    } single_t;

    single_t singles[10];

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        in_op     = 3'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        rst       = 1'b0;
        model_reset();
        #1;
        rst = 1'b1;
        #1;
        chk("init_out_valid", out_valid, 1'b0);
        chk("init_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;

        singles = '{'{3'd0, 8'h00, 1'b0}, '{3'd0, 8'h01, 1'b1},
                    '{3'd1, 8'hFF, 1'b1}, '{3'd1, 8'hFE, 1'b0},
                    '{3'd2, 8'h03, 1'b0}, '{3'd2, 8'h07, 1'b1},
                    '{3'd3, 8'h00, 1'b1}, '{3'd4, 8'hFF, 1'b0},
                    '{3'd5, 8'h07, 1'b0}, '{3'd5, 8'h00, 1'b1}};
        foreach (singles[i]) begin
            cycle(1'b1, singles[i].d, singles[i].op, 1'b0, 1'b1);
            chk($sformatf("single_valid_op%0d", singles[i].op), out_valid, 1'b1);
            chk($sformatf("single_bit_op%0d_%h", singles[i].op, singles[i].d), out_bit, singles[i].exp);
            chk("single_count", out_count, 8'd1);
        end

        // Accumulate frames
        cycle(1'b1, 8'h00, 3'd6, 1'b0, 1'b1);
        chk("accor_beat1_valid", out_valid, 1'b0);
        cycle(1'b1, 8'h00, 3'd6, 1'b0, 1'b1);
        chk("accor_beat2_valid", out_valid, 1'b0);
        cycle(1'b1, 8'h10, 3'd6, 1'b1, 1'b1);
        chk("accor_valid", out_valid, 1'b1);
        chk("accor_bit", out_bit, 1'b1);
        chk("accor_count", out_count, 8'd3);
        cycle(1'b1, 8'hFF, 3'd7, 1'b0, 1'b1);
        cycle(1'b1, 8'hFF, 3'd7, 1'b0, 1'b1);
        cycle(1'b1, 8'h7F, 3'd7, 1'b1, 1'b1);
        chk("accand_bit", out_bit, 1'b0);
        chk("accand_count", out_count, 8'd3);
        cycle(1'b1, 8'h00, 3'd6, 1'b1, 1'b1);
        chk("accor_single_valid", out_valid, 1'b1);
        chk("accor_single_bit", out_bit, 1'b0);
        chk("accor_single_count", out_count, 8'd1);

        // Op latching: second beat's in_op is ignored
        cycle(1'b1, 8'h00, 3'd6, 1'b0, 1'b1);
        cycle(1'b1, 8'h01, 3'd1, 1'b1, 1'b1);
        chk("latch_bit", out_bit, 1'b1);
        chk("latch_count", out_count, 8'd2);
        cycle(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);

        // Backpressure
        cycle(1'b1, 8'hFF, 3'd1, 1'b0, 1'b0);
        chk("bp_first_valid", out_valid, 1'b1);
        chk("bp_first_bit", out_bit, 1'b1);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
            chk("bp_in_ready_low", in_ready, 1'b0);
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_hold_bit", out_bit, 1'b1);
        end
        cycle(1'b1, 8'h00, 3'd0, 1'b0, 1'b1);
        chk("bp_second_valid", out_valid, 1'b1);
        chk("bp_second_bit", out_bit, 1'b0);
        chk("bp_second_count", out_count, 8'd1);
        cycle(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        chk("bp_drained", out_valid, 1'b0);

        // Reset with a held result
        cycle(1'b1, 8'h01, 3'd0, 1'b0, 1'b0);
        chk("pre_rst_valid", out_valid, 1'b1);
        do_reset();

        // Reset discards a partial frame
        cycle(1'b1, 8'hFF, 3'd7, 1'b0, 1'b1);
        cycle(1'b1, 8'hFF, 3'd7, 1'b0, 1'b1);
        do_reset();
        cycle(1'b1, 8'hFF, 3'd7, 1'b1, 1'b1);
        chk("post_rst_bit", out_bit, 1'b1);
        chk("post_rst_count", out_count, 8'd1);

        // Count saturation
        for (int k = 0; k < 299; k++) cycle(1'b1, 8'h00, 3'd6, 1'b0, 1'b1);
        chk("sat_no_valid", out_valid, 1'b0);
        cycle(1'b1, 8'h80, 3'd6, 1'b1, 1'b1);
        chk("sat_bit", out_bit, 1'b1);
        chk("sat_count", out_count, 8'd255);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 3) != 0, rand_data(), 3'($urandom_range(0, 7)),
                      $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
            end
        end
        cycle(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
